// File: rtl/usb_rx_txn_ctrl_if.sv
// Handshake bundle between the host transaction FSM / receive stream (master)
// and the receive transaction sequencer (slave).
interface usb_rx_txn_ctrl_if;
    logic       start;
    logic       expect_data;
    logic       NRZI_active;
    logic       stream_done;
    logic       stream_error;
    logic [3:0] rx_pid;
    logic       decode;
    logic       kill;
    logic       busy;
    logic       retry_req;
    logic       result_valid;
    logic [2:0] result;
    logic [3:0] retry_cnt;

    modport master (
        output start, expect_data, NRZI_active, stream_done, stream_error, rx_pid,
        input  decode, kill, busy, retry_req, result_valid, result, retry_cnt
    );

    modport slave (
        input  start, expect_data, NRZI_active, stream_done, stream_error, rx_pid,
        output decode, kill, busy, retry_req, result_valid, result, retry_cnt
    );
endinterface

// File: rtl/usb_rx_txn_ctrl.sv
// Receive transaction sequencer: arms the receive stream, enforces turnaround
// and packet watchdogs, classifies the received PID and manages bounded retries.
module usb_rx_txn_ctrl #(
    parameter logic [15:0] TURNAROUND = 16'd255,
    parameter logic [15:0] PKT_MAX    = 16'd200,
    parameter logic [3:0]  MAX_RETRY  = 4'd8
) (
    input logic              clk,
    input logic              rst_L,
    usb_rx_txn_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, ARM, WAIT_START, RECV, KILL, EVAL, WAIT_RESEND, DONE
    } state_t;

    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_DATA0 = 4'b0011;

    localparam logic [2:0] RES_ACK      = 3'd0;
    localparam logic [2:0] RES_NAK      = 3'd1;
    localparam logic [2:0] RES_DATA_OK  = 3'd2;
    localparam logic [2:0] RES_FAIL_TO  = 3'd3;
    localparam logic [2:0] RES_FAIL_ERR = 3'd4;

    state_t      state;
    logic [15:0] timer;
    logic        exp_q;
    logic        err_q;
    logic [3:0]  pid_q;
    logic        decode_q, kill_q, busy_q, retry_req_q, result_valid_q;
    logic [2:0]  result_q;
    logic [3:0]  retry_cnt_q;

    logic        eval_ok;
    logic [2:0]  eval_res;
    logic        fail_go;
    logic [2:0]  fail_res;
    logic [3:0]  cnt_next;

    always_comb begin
        eval_ok  = 1'b0;
        eval_res = RES_ACK;
        if (!err_q) begin
            if (!exp_q && pid_q == PID_ACK) begin
                eval_ok  = 1'b1;
                eval_res = RES_ACK;
            end else if (!exp_q && pid_q == PID_NAK) begin
                eval_ok  = 1'b1;
                eval_res = RES_NAK;
            end else if (exp_q && pid_q == PID_DATA0) begin
                eval_ok  = 1'b1;
                eval_res = RES_DATA_OK;
            end
        end

        // FAIL is resolved on the transition into it, so retry_req/result_valid
        // appear one cycle after the failing condition is seen.
        fail_go  = 1'b0;
        fail_res = RES_FAIL_TO;
        case (state)
            WAIT_START: fail_go = !bus.stream_done && !bus.NRZI_active && (timer == TURNAROUND);
            KILL:       fail_go = 1'b1;
            EVAL: begin
                fail_go  = !eval_ok;
                fail_res = RES_FAIL_ERR;
            end
            default: ;
        endcase
        cnt_next = retry_cnt_q + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_L) begin
            state          <= IDLE;
            timer          <= '0;
            exp_q          <= 1'b0;
            err_q          <= 1'b0;
            pid_q          <= '0;
            decode_q       <= 1'b0;
            kill_q         <= 1'b1;
            busy_q         <= 1'b0;
            retry_req_q    <= 1'b0;
            result_valid_q <= 1'b0;
            result_q       <= RES_ACK;
            retry_cnt_q    <= '0;
        end else begin
            decode_q       <= 1'b0;
            kill_q         <= 1'b1;
            retry_req_q    <= 1'b0;
            result_valid_q <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    exp_q       <= bus.expect_data;
                    retry_cnt_q <= '0;
                    result_q    <= RES_ACK;
                    decode_q    <= 1'b1;
                    busy_q      <= 1'b1;
                    state       <= ARM;
                end
                ARM: begin
                    timer <= '0;
                    state <= WAIT_START;
                end
                WAIT_START: begin
                    if (bus.stream_done) begin
                        err_q <= bus.stream_error;
                        pid_q <= bus.rx_pid;
                        state <= EVAL;
                    end else if (bus.NRZI_active) begin
                        timer <= '0;
                        state <= RECV;
                    end else if (!fail_go && timer != '1) begin
                        timer <= timer + 16'd1;
                    end
                end
                RECV: begin
                    if (bus.stream_done) begin
                        err_q <= bus.stream_error;
                        pid_q <= bus.rx_pid;
                        state <= EVAL;
                    end else if (timer == PKT_MAX) begin
                        kill_q <= 1'b0;
                        state  <= KILL;
                    end else if (timer != '1) begin
                        timer <= timer + 16'd1;
                    end
                end
                EVAL: if (eval_ok) begin
                    result_q       <= eval_res;
                    result_valid_q <= 1'b1;
                    state          <= DONE;
                end
                WAIT_RESEND: if (bus.start) begin
                    exp_q    <= bus.expect_data;
                    decode_q <= 1'b1;
                    state    <= ARM;
                end
                DONE: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: ;
            endcase

            if (fail_go) begin
                retry_cnt_q <= cnt_next;
                if (cnt_next < MAX_RETRY) begin
                    retry_req_q <= 1'b1;
                    state       <= WAIT_RESEND;
                end else begin
                    result_q       <= fail_res;
                    result_valid_q <= 1'b1;
                    state          <= DONE;
                end
            end
        end
    end

    assign bus.decode       = decode_q;
    assign bus.kill         = kill_q;
    assign bus.busy         = busy_q;
    assign bus.retry_req    = retry_req_q;
    assign bus.result_valid = result_valid_q;
    assign bus.result       = result_q;
    assign bus.retry_cnt    = retry_cnt_q;
endmodule

// File: tb/tb_usb_rx_txn_ctrl.sv
// Bench for usb_rx_txn_ctrl: directed scenarios plus randomized transactions,
// checked every cycle against a deadline-based transaction model.
module tb_usb_rx_txn_ctrl;
    localparam int TURN = 255;
    localparam int PKT  = 200;
    localparam int MAXR = 8;

    logic clk;
    logic rst_L;
    int   checks = 0;
    int   errors = 0;
    int   kill_lows = 0;

    usb_rx_txn_ctrl_if ifc ();

    usb_rx_txn_ctrl #(
        .TURNAROUND(16'd255),
        .PKT_MAX   (16'd200),
        .MAX_RETRY (4'd8)
    ) dut (
        .clk  (clk),
        .rst_L(rst_L),
        .bus  (ifc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model phases: where the transaction is, with absolute-edge deadlines.
    localparam int P_IDLE = 0, P_ARM = 1, P_WAIT = 2, P_RECV = 3;
    localparam int P_KILL = 4, P_EVAL = 5, P_RESEND = 6, P_DONE = 7;

    int   edge_n = 0;
    int   m_ph = P_IDLE;
    int   deadline = 0;
    int   m_cnt = 0;
    int   m_res = 0;
    bit   m_exp, m_err;
    logic [3:0] m_pid;
    bit   e_dec, e_kill = 1'b1, e_busy, e_rr, e_rv;

    function automatic int classify(input bit exp, input bit err, input logic [3:0] pid);
        if (err) return -1;
        if (!exp && pid == 4'b0010) return 0;
        if (!exp && pid == 4'b1010) return 1;
        if (exp && pid == 4'b0011) return 2;
        return -1;
    endfunction

    always @(posedge clk) begin
        int fail;
        int r;
        edge_n++;
        if (!rst_L) begin
            m_ph = P_IDLE; m_cnt = 0; m_res = 0;
            e_dec = 0; e_kill = 1; e_busy = 0; e_rr = 0; e_rv = 0;
        end else begin
            fail = -1;
            e_dec = 0; e_kill = 1; e_rr = 0; e_rv = 0;
            case (m_ph)
                P_IDLE: if (ifc.start) begin
                    m_exp = ifc.expect_data; m_cnt = 0; m_res = 0; m_ph = P_ARM; e_dec = 1;
                end
                P_ARM: begin
                    m_ph = P_WAIT; deadline = edge_n + TURN + 1;
                end
                P_WAIT: begin
                    if (ifc.stream_done) begin
                        m_err = ifc.stream_error; m_pid = ifc.rx_pid; m_ph = P_EVAL;
                    end else if (ifc.NRZI_active) begin
                        m_ph = P_RECV; deadline = edge_n + PKT + 1;
                    end else if (edge_n == deadline) fail = 3;
                end
                P_RECV: begin
                    if (ifc.stream_done) begin
                        m_err = ifc.stream_error; m_pid = ifc.rx_pid; m_ph = P_EVAL;
                    end else if (edge_n == deadline) begin
                        m_ph = P_KILL; e_kill = 0;
                    end
                end
                P_KILL: fail = 3;
                P_EVAL: begin
                    r = classify(m_exp, m_err, m_pid);
                    if (r < 0) fail = 4;
                    else begin m_res = r; m_ph = P_DONE; e_rv = 1; end
                end
                P_RESEND: if (ifc.start) begin
                    m_exp = ifc.expect_data; m_ph = P_ARM; e_dec = 1;
                end
                default: m_ph = P_IDLE;
            endcase
            if (fail >= 0) begin
                m_cnt++;
                if (m_cnt < MAXR) begin m_ph = P_RESEND; e_rr = 1; end
                else begin m_res = fail; m_ph = P_DONE; e_rv = 1; end
            end
            e_busy = (m_ph != P_IDLE);
        end
    end

    always @(negedge clk) begin
        if (ifc.kill === 1'b0) kill_lows++;
        if (edge_n > 0) begin
            checks++;
            if ({ifc.decode, ifc.kill, ifc.busy, ifc.retry_req, ifc.result_valid, ifc.result, ifc.retry_cnt}
                !== {e_dec, e_kill, e_busy, e_rr, e_rv, 3'(m_res), 4'(m_cnt)}) begin
                errors++;
                $display("FAIL cycle_model edge %0d: dut dec=%b kill=%b busy=%b rr=%b rv=%b res=%0d cnt=%0d, model dec=%b kill=%b busy=%b rr=%b rv=%b res=%0d cnt=%0d",
                         edge_n, ifc.decode, ifc.kill, ifc.busy, ifc.retry_req, ifc.result_valid,
                         ifc.result, ifc.retry_cnt, e_dec, e_kill, e_busy, e_rr, e_rv, m_res, m_cnt);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_start(input bit exp);
        ifc.start = 1'b1;
        ifc.expect_data = exp;
        tick();
        ifc.start = 1'b0;
    endtask

    // mode: 0 activity then done, 1 done without activity, 2 silent, 3 stuck active
    task automatic do_attempt(input int mode, input int d1, input int d2,
                              input logic [3:0] pid, input bit err, input bit junk);
        if (mode == 2) return;
        repeat (d1) tick();
        if (mode != 1) ifc.NRZI_active = 1'b1;
        if (mode == 3) return;
        for (int j = 0; j < d2; j++) begin
            ifc.start = junk && (j == 0);
            tick();
        end
        ifc.start = 1'b0;
        ifc.stream_done = 1'b1;
        ifc.rx_pid = pid;
        ifc.stream_error = err;
        tick();
        ifc.stream_done = 1'b0;
        ifc.NRZI_active = 1'b0;
        ifc.rx_pid = 4'($urandom_range(0, 15));
        ifc.stream_error = 1'($urandom_range(0, 1));
    endtask

    // kind: 1 retry_req, 2 result_valid, 0 bound expired
    task automatic wait_outcome(output int kind);
        kind = 0;
        for (int i = 0; i < 1000; i++) begin
            if (ifc.retry_req === 1'b1) begin kind = 1; break; end
            if (ifc.result_valid === 1'b1) begin kind = 2; break; end
            tick();
        end
        if (kind == 0) chk("outcome_timeout", 0, 1);
        ifc.NRZI_active = 1'b0;
    endtask

    function automatic logic [3:0] good_pid(input bit exp);
        if (exp) return 4'b0011;
        return ($urandom_range(0, 1) != 0) ? 4'b0010 : 4'b1010;
    endfunction

    task automatic run_random_txn();
        int  kind, sel;
        bit  exp;
        exp = 1'($urandom_range(0, 1));
        pulse_start(exp);
        for (int a = 0; a < 20; a++) begin
            sel = $urandom_range(0, 19);
            if (sel <= 7)       do_attempt(0, $urandom_range(1, 30), $urandom_range(2, 60), good_pid(exp), 0, 0);
            else if (sel <= 10) do_attempt(0, $urandom_range(1, 30), $urandom_range(2, 60), 4'($urandom_range(0, 15)), 0, 0);
            else if (sel <= 12) do_attempt(0, $urandom_range(1, 30), $urandom_range(2, 60), good_pid(exp), 1, 0);
            else if (sel <= 14) do_attempt(1, $urandom_range(1, 30), $urandom_range(2, 60), good_pid(exp), 0, 1);
            else if (sel == 15) do_attempt(2, 0, 0, 4'b0, 0, 0);
            else if (sel == 16) do_attempt(3, $urandom_range(1, 30), 0, 4'b0, 0, 0);
            else                do_attempt(0, $urandom_range(1, 30), $urandom_range(2, 60), good_pid(exp), 0, 1);
            wait_outcome(kind);
            if (kind != 1) break;
            repeat ($urandom_range(0, 4)) tick();
            exp = 1'($urandom_range(0, 1));
            pulse_start(exp);
        end
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int kind, n, k0;
        ifc.start = 0; ifc.expect_data = 0; ifc.NRZI_active = 0;
        ifc.stream_done = 0; ifc.stream_error = 0; ifc.rx_pid = 4'b0;
        rst_L = 1'b0;
        repeat (3) tick();
        chk("reset_kill", ifc.kill, 1);
        chk("reset_busy", ifc.busy, 0);
        rst_L = 1'b1;
        tick();

        // 1: ACK handshake, start->decode 1 cycle, done->result_valid 2 cycles
        pulse_start(0);
        chk("t1_decode", ifc.decode, 1);
        do_attempt(0, 4, 35, 4'b0010, 0, 0);
        chk("t1_rv_early", ifc.result_valid, 0);
        tick();
        chk("t1_rv", ifc.result_valid, 1);
        chk("t1_result", ifc.result, 0);
        chk("t1_cnt", ifc.retry_cnt, 0);
        tick();
        chk("t1_idle", ifc.busy, 0);

        // 2: no bus activity at all
        k0 = kill_lows;
        ifc.start = 1; ifc.expect_data = 1;
        n = 0;
        for (int i = 0; i < 400; i++) begin
            tick(); ifc.start = 0; n++;
            if (ifc.retry_req === 1'b1) break;
        end
        chk("t2_rr_latency", n, TURN + 3);
        kind = 1;
        for (int a = 1; a < MAXR && kind == 1; a++) begin
            pulse_start(1);
            wait_outcome(kind);
        end
        chk("t2_kind", kind, 2);
        chk("t2_result", ifc.result, 3);
        chk("t2_cnt", ifc.retry_cnt, 8);
        chk("t2_no_kill", kill_lows - k0, 0);
        tick();

        // 3: stuck activity -> kill then retry_req; resend gets ACK
        pulse_start(0);
        tick();
        ifc.NRZI_active = 1;
        n = 0;
        for (int i = 0; i < 400; i++) begin
            tick(); n++;
            if (ifc.kill === 1'b0) break;
        end
        chk("t3_kill_latency", n, PKT + 2);
        tick();
        chk("t3_kill_release", ifc.kill, 1);
        chk("t3_rr", ifc.retry_req, 1);
        ifc.NRZI_active = 0;
        pulse_start(0);
        do_attempt(0, 3, 8, 4'b0010, 0, 0);
        wait_outcome(kind);
        chk("t3_kind", kind, 2);
        chk("t3_cnt", ifc.retry_cnt, 1);
        tick();

        // 4: wrong PID class then ACK
        pulse_start(0);
        do_attempt(0, 5, 10, 4'b0011, 0, 0);
        wait_outcome(kind);
        chk("t4_retry", kind, 1);
        pulse_start(0);
        do_attempt(0, 5, 10, 4'b0010, 0, 0);
        wait_outcome(kind);
        chk("t4_kind", kind, 2);
        chk("t4_result", ifc.result, 0);
        chk("t4_cnt", ifc.retry_cnt, 1);
        tick();

        // 5: stream error on every attempt
        pulse_start(1);
        kind = 1;
        for (int a = 0; a < MAXR && kind == 1; a++) begin
            if (a > 0) pulse_start(1);
            do_attempt(0, 3, 6, 4'b0011, 1, 0);
            wait_outcome(kind);
        end
        chk("t5_kind", kind, 2);
        chk("t5_result", ifc.result, 4);
        chk("t5_cnt", ifc.retry_cnt, 8);
        tick();

        // 5b: stream_done on the exact watchdog cycle
        k0 = kill_lows;
        pulse_start(0);
        tick();
        ifc.NRZI_active = 1;
        repeat (PKT + 1) tick();
        ifc.stream_done = 1; ifc.rx_pid = 4'b0010; ifc.stream_error = 0;
        tick();
        ifc.stream_done = 0; ifc.NRZI_active = 0;
        wait_outcome(kind);
        chk("t5b_kind", kind, 2);
        chk("t5b_result", ifc.result, 0);
        chk("t5b_no_kill", kill_lows - k0, 0);
        tick();

        // 6: start while busy ignored; reset mid-RECV
        pulse_start(0);
        tick();
        ifc.NRZI_active = 1;
        repeat (10) tick();
        pulse_start(1);
        chk("t6_ignored_start", ifc.decode, 0);
        rst_L = 0;
        tick();
        chk("t6_rst_outputs", {ifc.decode, ifc.kill, ifc.busy, ifc.retry_req, ifc.result_valid},
            5'b01000);
        chk("t6_rst_result", ifc.result, 0);
        chk("t6_rst_cnt", ifc.retry_cnt, 0);
        rst_L = 1;
        ifc.NRZI_active = 0;
        tick();

        for (int t = 0; t < 40; t++) run_random_txn();
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
